stepper_channel_sync: RTL and testbench
=======================================

// Module: stepper_channel_sync
// PURPOSE
//  Clock-synchronous, parametrised successor to the asynchronous step/dir stepper channel.
//  Samples external step/dir, advances a 16-entry quarter-step phase table for one A3988 bridge pair,
//  and adds realignment on microstep change, a step-rate lockout, enable/coast and a signed position counter.
//  Sits between the PID/step generator and the A3988 phase pins; one instance per axis.
// PARAMETERS
//  POS_WIDTH        32  width of signed position counter (quarter-step units)
//  SYNC_STAGES      2   flops in step/dir synchroniser (>=2)
//  MIN_STEP_CYCLES  4   minimum clk cycles between accepted steps; closer steps are dropped
//  RESET_INDEX      2   table index after reset (a full-step point)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          asynchronous, active-high reset
//  step           in   1          async step request; rising edge = one step
//  dir            in   1          async direction; 1 = index up, 0 = index down
//  microstep      in   4          1=full, 2=half, 4=quarter; other codes invalid
//  modified_mode  in   1          drive I0=1 at indices 2,6,10,14 (A3988 modified sequence)
//  enable         in   1          0 = coast both bridges, steps ignored
//  pos_load       in   1          load pos_value into position
//  pos_value      in   POS_WIDTH  preset value
//  ovr_clear      in   1          clears step_overrun
//  phase1_I0/I1/phase, phase2_I0/I1/phase  out 1 each  A3988 control pins
//  position       out  POS_WIDTH  signed quarter-step position
//  seq_index      out  4          current table index
//  step_ack       out  1          1-cycle pulse per accepted step
//  step_overrun   out  1          sticky: a step was dropped by lockout
//  cfg_err        out  1          1 while microstep code invalid
// BEHAVIOUR
//  Reset: seq_index=RESET_INDEX, position=0, step_ack=0, step_overrun=0, cfg_err=0; phase pins show RESET_INDEX entry
//   with modified_mode=0 (p1=001,p2=001 as {I0,I1,ph}); lockout counter expired.
//  Table idx->{p1_I0,p1_I1,p1_ph,p2_I0,p2_I1,p2_ph}, M=modified_mode:
//   0:111001 1:011001 2:M01M01 3:001011 4:001111 5:001010 6:M01M00 7:011000
//   8:110000 9:010000 10:M00M00 11:000010 12:000110 13:000011 14:M00M01 15:010001
//  Grid: full = {2,6,10,14}; half = even indices; quarter = all.
//  Step acceptance: synchronised step rising edge AND enable AND cfg_err=0 AND lockout expired.
//   Accepted: dir=1 -> next = smallest grid index > seq_index (mod 16); dir=0 -> largest grid index < seq_index (mod 16).
//   On-grid this is +/-4,2,1; off-grid (after microstep change) snaps to grid, delta 1..3.
//   position += signed(next-seq_index mod 16 in direction), two's-complement wrap; step_ack pulses; lockout reloads MIN_STEP_CYCLES-1.
//  Rejected by lockout: index/position unchanged, step_overrun<=1 (ovr_clear same cycle: set wins).
//  Rejected by enable=0 or cfg_err: silently ignored, no overrun.
//  dir is synchronised with step through identical SYNC_STAGES; dir must be stable SYNC_STAGES+1 cycles before step edge.
//  Latency: phase pins/seq_index/position change on the (SYNC_STAGES+2)th clk edge after the first edge sampling step=1.
//  enable=0: all six pins forced 1,1,x->{1,1,0} both phases (coast) within 1 cycle; seq_index held; enable=1 restores table entry.
//  modified_mode is combinationally folded into registered output next cycle (1-cycle latency, no index change).
//  pos_load: position<=pos_value next edge; simultaneous accepted step still moves index, load value wins for position.
//  microstep change mid-run: takes effect on next accepted step (snap rule); no output change by itself.
//  Reset asserted mid-operation: all state returns to reset values immediately; synchroniser cleared (no phantom edge).
// STRUCTURE
//  Package stepper_pkg: microstep code localparams (MS_FULL=1, MS_HALF=2, MS_QTR=4), 16-entry phase table function
//   phase_lookup(idx, modified), grid_next(idx, dir, ms) function.
//  Sub-module stepper_sync_edge: SYNC_STAGES synchroniser for step/dir + rising-edge pulse; two per channel not needed (shared).
// TESTING
//  1 quarter, dir=1, 20 steps spaced 10 cycles from idx 2 -> idx 3,4..15,0..6; position=20; step_ack x20.
//  2 full, dir=0, 4 steps from idx 2 -> 14,10,6,2; position=-16; pins at 14 = 000001 (M=0), 100101 (M=1).
//  3 quarter to idx 3, switch to full, dir=1 step -> idx 6, position +3; then dir=0 step -> idx 2.
//  4 steps 2 cycles apart, MIN_STEP_CYCLES=4 -> every 2nd dropped, step_overrun=1; ovr_clear -> 0.
//  5 enable=0 with 5 steps -> pins 110110, idx/position unchanged; microstep=3 -> cfg_err=1, steps ignored.
//  6 pos_load=1 pos_value=-5 with simultaneous step; then rst mid-step pulse -> position=0, idx 2, no step_ack.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the synchronous stepper channel: microstep codes,
// A3988 quarter-step phase table and microstep grid navigation.
package stepper_pkg;

    localparam logic [3:0] MS_FULL = 4'd1;
    localparam logic [3:0] MS_HALF = 4'd2;
    localparam logic [3:0] MS_QTR  = 4'd4;

    typedef struct packed {
        logic p1_i0;
        logic p1_i1;
        logic p1_ph;
        logic p2_i0;
        logic p2_i1;
        logic p2_ph;
    } phase_pins_t;

    // Both bridges in coast: I0=I1=1, phase don't-care driven low
    localparam phase_pins_t PINS_COAST = 6'b110_110;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_ACCEPT,
        STEP_DROP
    } step_evt_t;

    function automatic logic ms_valid(input logic [3:0] ms);
        return (ms == MS_FULL) || (ms == MS_HALF) || (ms == MS_QTR);
    endfunction

    function automatic phase_pins_t phase_lookup(input logic [3:0] idx, input logic modified);
        logic [5:0] p;
        case (idx)
            4'd0:  p = 6'b111_001;
            4'd1:  p = 6'b011_001;
            4'd2:  p = 6'b001_001;
            4'd3:  p = 6'b001_011;
            4'd4:  p = 6'b001_111;
            4'd5:  p = 6'b001_010;
            4'd6:  p = 6'b001_000;
            4'd7:  p = 6'b011_000;
            4'd8:  p = 6'b110_000;
            4'd9:  p = 6'b010_000;
            4'd10: p = 6'b000_000;
            4'd11: p = 6'b000_010;
            4'd12: p = 6'b000_110;
            4'd13: p = 6'b000_011;
            4'd14: p = 6'b000_001;
            4'd15: p = 6'b010_001;
        endcase
        // Full-step points carry the modified-sequence I0 bit on both bridges
        if (idx[1:0] == 2'b10) begin
            p = p | {modified, 2'b00, modified, 2'b00};
        end
        return phase_pins_t'(p);
    endfunction

    function automatic logic on_grid(input logic [3:0] idx, input logic [3:0] ms);
        case (ms)
            MS_FULL: return idx[1:0] == 2'b10;
            MS_HALF: return !idx[0];
            default: return 1'b1;
        endcase
    endfunction

    // Nearest grid point strictly past idx in the step direction (mod 16)
    function automatic logic [3:0] grid_next(input logic [3:0] idx, input logic dir,
                                             input logic [3:0] ms);
        logic [3:0] cand;
        logic       found;
        logic [3:0] res;
        res   = idx;
        found = 1'b0;
        for (int unsigned d = 1; d <= 4; d++) begin
            cand = dir ? idx + 4'(d) : idx - 4'(d);
            if (!found && on_grid(cand, ms)) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stepper_channel_sync_if.sv
// Control/status bundle between the step generator side and one stepper channel.
interface stepper_channel_sync_if #(
    parameter int unsigned POS_WIDTH = 32
);
    logic                 step;
    logic                 dir;
    logic [3:0]           microstep;
    logic                 modified_mode;
    logic                 enable;
    logic                 pos_load;
    logic [POS_WIDTH-1:0] pos_value;
    logic                 ovr_clear;

    logic                 phase1_I0;
    logic                 phase1_I1;
    logic                 phase1_phase;
    logic                 phase2_I0;
    logic                 phase2_I1;
    logic                 phase2_phase;
    logic [POS_WIDTH-1:0] position;
    logic [3:0]           seq_index;
    logic                 step_ack;
    logic                 step_overrun;
    logic                 cfg_err;

    modport master (
        output step, dir, microstep, modified_mode, enable, pos_load, pos_value, ovr_clear,
        input  phase1_I0, phase1_I1, phase1_phase, phase2_I0, phase2_I1, phase2_phase,
        input  position, seq_index, step_ack, step_overrun, cfg_err
    );

    modport slave (
        input  step, dir, microstep, modified_mode, enable, pos_load, pos_value, ovr_clear,
        output phase1_I0, phase1_I1, phase1_phase, phase2_I0, phase2_I1, phase2_phase,
        output position, seq_index, step_ack, step_overrun, cfg_err
    );
endinterface

// File: rtl/stepper_sync_edge.sv
// Shared step/dir synchroniser with registered rising-edge detect on step;
// dir travels through an identical pipeline so it stays aligned with the pulse.
module stepper_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic dir,
    output logic step_rise,
    output logic dir_sync
);
    logic [SYNC_STAGES-1:0] step_sr;
    logic [SYNC_STAGES-1:0] dir_sr;
    logic                   step_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sr   <= '0;
            dir_sr    <= '0;
            step_prev <= 1'b0;
            step_rise <= 1'b0;
            dir_sync  <= 1'b0;
        end else begin
            step_sr   <= {step_sr[SYNC_STAGES-2:0], step};
            dir_sr    <= {dir_sr[SYNC_STAGES-2:0], dir};
            step_prev <= step_sr[SYNC_STAGES-1];
            step_rise <= step_sr[SYNC_STAGES-1] & ~step_prev;
            dir_sync  <= dir_sr[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/stepper_channel_sync.sv
// Synchronous step/dir stepper channel driving one A3988 bridge pair, with
// microstep snapping, step-rate lockout, coast enable and signed position.
module stepper_channel_sync
    import stepper_pkg::*;
#(
    parameter int unsigned POS_WIDTH       = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned MIN_STEP_CYCLES = 4,
    parameter int unsigned RESET_INDEX     = 2
) (
    input logic                   clk,
    input logic                   rst,
    stepper_channel_sync_if.slave bus
);
    localparam int unsigned LOCK_W = (MIN_STEP_CYCLES > 1) ? $clog2(MIN_STEP_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_RELOAD =
        (MIN_STEP_CYCLES > 0) ? LOCK_W'(MIN_STEP_CYCLES - 1) : '0;

    logic                 step_rise;
    logic                 dir_sync;
    logic [3:0]           seq_index;
    logic [POS_WIDTH-1:0] position;
    logic                 step_ack;
    logic                 step_overrun;
    logic                 cfg_err;
    logic [3:0]           ms_q;
    logic [LOCK_W-1:0]    lock_cnt;
    phase_pins_t          pins_q;

    step_evt_t            evt;
    logic [3:0]           idx_next;
    logic [3:0]           delta;
    logic [POS_WIDTH-1:0] pos_next;

    stepper_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .step     (bus.step),
        .dir      (bus.dir),
        .step_rise(step_rise),
        .dir_sync (dir_sync)
    );

    always_comb begin
        evt      = STEP_NONE;
        idx_next = seq_index;
        delta    = '0;
        pos_next = position;
        if (step_rise && bus.enable && !cfg_err) begin
            evt = (lock_cnt == '0) ? STEP_ACCEPT : STEP_DROP;
        end
        if (evt == STEP_ACCEPT) begin
            idx_next = grid_next(seq_index, dir_sync, ms_q);
            delta    = dir_sync ? idx_next - seq_index : seq_index - idx_next;
            pos_next = dir_sync ? position + POS_WIDTH'(delta)
                                : position - POS_WIDTH'(delta);
        end
        // A load overrides the step's position update; the index still moves
        if (bus.pos_load) begin
            pos_next = bus.pos_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_index    <= 4'(RESET_INDEX);
            position     <= '0;
            step_ack     <= 1'b0;
            step_overrun <= 1'b0;
            cfg_err      <= 1'b0;
            ms_q         <= MS_QTR;
            lock_cnt     <= '0;
            pins_q       <= phase_lookup(4'(RESET_INDEX), 1'b0);
        end else begin
            seq_index <= idx_next;
            position  <= pos_next;
            step_ack  <= (evt == STEP_ACCEPT);
            ms_q      <= bus.microstep;
            cfg_err   <= !ms_valid(bus.microstep);
            if (evt == STEP_DROP) begin
                step_overrun <= 1'b1;
            end else if (bus.ovr_clear) begin
                step_overrun <= 1'b0;
            end
            if (evt == STEP_ACCEPT) begin
                lock_cnt <= LOCK_RELOAD;
            end else if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - 1'b1;
            end
            pins_q <= bus.enable ? phase_lookup(idx_next, bus.modified_mode) : PINS_COAST;
        end
    end

    assign bus.phase1_I0    = pins_q.p1_i0;
    assign bus.phase1_I1    = pins_q.p1_i1;
    assign bus.phase1_phase = pins_q.p1_ph;
    assign bus.phase2_I0    = pins_q.p2_i0;
    assign bus.phase2_I1    = pins_q.p2_i1;
    assign bus.phase2_phase = pins_q.p2_ph;
    assign bus.position     = position;
    assign bus.seq_index    = seq_index;
    assign bus.step_ack     = step_ack;
    assign bus.step_overrun = step_overrun;
    assign bus.cfg_err      = cfg_err;
endmodule

// File: tb/tb_stepper_channel_sync.sv
// Scoreboard bench for stepper_channel_sync: each expected step outcome is
// queued when the step is driven and compared when step_ack is seen.
module tb_stepper_channel_sync;

    localparam int unsigned SYNC = 2;
    localparam int unsigned MINC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stepper_channel_sync_if #(.POS_WIDTH(32)) bus ();

    stepper_channel_sync #(
        .POS_WIDTH      (32),
        .SYNC_STAGES    (SYNC),
        .MIN_STEP_CYCLES(MINC),
        .RESET_INDEX    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        longint pos;
        int     pins;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     ack_cnt      = 0;
    int     m_idx;
    longint m_pos;
    int     a0;

    logic [5:0] base_tbl [16] = '{
        6'b111001, 6'b011001, 6'b001001, 6'b001011,
        6'b001111, 6'b001010, 6'b001000, 6'b011000,
        6'b110000, 6'b010000, 6'b000000, 6'b000010,
        6'b000110, 6'b000011, 6'b000001, 6'b010001
    };

    task automatic check_val(input string tag, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int exp_pins(input int idx, input bit m);
        int p;
        p = int'(base_tbl[idx]);
        if (m && (idx % 4 == 2)) p = p | 6'b100100;
        return p;
    endfunction

    function automatic int dut_pins();
        return int'({bus.phase1_I0, bus.phase1_I1, bus.phase1_phase,
                     bus.phase2_I0, bus.phase2_I1, bus.phase2_phase});
    endfunction

    // Grid arithmetic: full = 2+4k, half = 2k, quarter = k
    function automatic int model_next(input int idx, input bit d, input int ms);
        int size, off, r, n;
        size = (ms == 1) ? 4 : (ms == 2) ? 2 : 1;
        off  = (ms == 1) ? 2 : 0;
        r    = (idx - off + 16) % 16;
        if (d) n = (r / size + 1) * size;
        else   n = ((r + size - 1) / size - 1) * size;
        return (n + off + 32) % 16;
    endfunction

    task automatic push_step(input bit d);
        int     nxt;
        longint dl;
        nxt   = model_next(m_idx, d, int'(bus.microstep));
        dl    = d ? longint'((nxt - m_idx + 16) % 16) : -longint'((m_idx - nxt + 16) % 16);
        m_idx = nxt;
        m_pos = m_pos + dl;
        sb.push_back('{m_idx, m_pos, exp_pins(m_idx, bus.modified_mode)});
    endtask

    task automatic drive_step(input bit d, input bit accept, input int gap);
        bus.dir = d;
        repeat (SYNC + 1) @(negedge clk);
        if (accept) push_step(d);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] ms);
        rst               = 1'b1;
        bus.step          = 1'b0;
        bus.dir           = 1'b0;
        bus.microstep     = ms;
        bus.modified_mode = 1'b0;
        bus.enable        = 1'b1;
        bus.pos_load      = 1'b0;
        bus.pos_value     = '0;
        bus.ovr_clear     = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        m_idx = 2;
        m_pos = 0;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.step_ack) begin
            ack_cnt++;
            check_val("sb_nonempty_at_ack", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_val("ack_idx", longint'(bus.seq_index), mon_e.idx);
                check_val("ack_pos", longint'($signed(bus.position)), mon_e.pos);
                check_val("ack_pins", dut_pins(), mon_e.pins);
            end
        end
    end

    initial begin
        do_reset(4'd4);
        check_val("rst_idx", bus.seq_index, 2);
        check_val("rst_pos", longint'($signed(bus.position)), 0);
        check_val("rst_ack", bus.step_ack, 0);
        check_val("rst_ovr", bus.step_overrun, 0);
        check_val("rst_cfg", bus.cfg_err, 0);
        check_val("rst_pins", dut_pins(), 6'b001001);

        // quarter-step, 20 steps up
        a0 = ack_cnt;
        for (int i = 0; i < 20; i++) drive_step(1'b1, 1'b1, 10);
        repeat (8) @(negedge clk);
        check_val("t1_idx", bus.seq_index, 6);
        check_val("t1_pos", longint'($signed(bus.position)), 20);
        check_val("t1_acks", ack_cnt - a0, 20);
        check_val("t1_sb", sb.size(), 0);

        // full-step down, modified mode toggled at index 14
        do_reset(4'd1);
        drive_step(1'b0, 1'b1, 10);
        check_val("t2_pins14_m0", dut_pins(), 6'b000001);
        bus.modified_mode = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t2_pins14_m1", dut_pins(), 6'b100101);
        check_val("t2_idx_hold", bus.seq_index, 14);
        for (int i = 0; i < 3; i++) drive_step(1'b0, 1'b1, 10);
        repeat (8) @(negedge clk);
        check_val("t2_idx", bus.seq_index, 2);
        check_val("t2_pos", longint'($signed(bus.position)), -16);
        check_val("t2_sb", sb.size(), 0);

        // off-grid snap after microstep change
        do_reset(4'd4);
        drive_step(1'b1, 1'b1, 10);
        bus.microstep = 4'd1;
        repeat (4) @(negedge clk);
        check_val("t3_idx_hold", bus.seq_index, 3);
        check_val("t3_pins_hold", dut_pins(), exp_pins(3, 1'b0));
        drive_step(1'b1, 1'b1, 10);
        check_val("t3_up_pos", longint'($signed(bus.position)), 4);
        drive_step(1'b0, 1'b1, 10);
        check_val("t3_idx", bus.seq_index, 2);
        check_val("t3_sb", sb.size(), 0);

        // lockout: steps every 2 cycles, every second one dropped
        do_reset(4'd4);
        check_val("t4_ovr_pre", bus.step_overrun, 0);
        bus.dir = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        a0 = ack_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_step(1'b1);
            bus.step = 1'b1;
            @(negedge clk);
            bus.step = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_val("t4_acks", ack_cnt - a0, 3);
        check_val("t4_idx", bus.seq_index, 5);
        check_val("t4_ovr", bus.step_overrun, 1);
        bus.ovr_clear = 1'b1;
        @(negedge clk);
        bus.ovr_clear = 1'b0;
        check_val("t4_ovr_clr", bus.step_overrun, 0);
        check_val("t4_sb", sb.size(), 0);

        // coast and invalid microstep
        do_reset(4'd4);
        bus.enable = 1'b0;
        @(negedge clk);
        check_val("t5_coast", dut_pins(), 6'b110110);
        for (int i = 0; i < 5; i++) drive_step(1'b1, 1'b0, 6);
        check_val("t5_idx", bus.seq_index, 2);
        check_val("t5_pos", longint'($signed(bus.position)), 0);
        check_val("t5_ovr", bus.step_overrun, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        check_val("t5_restore", dut_pins(), 6'b001001);
        bus.microstep = 4'd3;
        repeat (2) @(negedge clk);
        check_val("t5_cfg", bus.cfg_err, 1);
        drive_step(1'b1, 1'b0, 8);
        check_val("t5_cfg_idx", bus.seq_index, 2);
        bus.microstep = 4'd4;
        repeat (2) @(negedge clk);
        check_val("t5_cfg_clr", bus.cfg_err, 0);

        // position load colliding with a step, then reset mid-step
        do_reset(4'd4);
        bus.dir = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        m_idx = model_next(m_idx, 1'b1, 4);
        m_pos = -5;
        sb.push_back('{m_idx, m_pos, exp_pins(m_idx, 1'b0)});
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.pos_load  = 1'b1;
        bus.pos_value = -32'sd5;
        @(negedge clk);
        bus.pos_load = 1'b0;
        repeat (6) @(negedge clk);
        check_val("t6_load_pos", longint'($signed(bus.position)), -5);
        check_val("t6_load_idx", bus.seq_index, 3);
        a0 = ack_cnt;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_idx_now", bus.seq_index, 2);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t6_rst_pos", longint'($signed(bus.position)), 0);
        check_val("t6_rst_idx", bus.seq_index, 2);
        check_val("t6_no_ack", ack_cnt - a0, 0);
        check_val("t6_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
